load_store_unit: RTL

Data-side initiator between the processor pipeline and the data port of the integrated instruction/data memory. It accepts one byte, halfword or word load/store request at a time through a valid/ready handshake and drives the memory's data_addr/data_in/mem_read/mem_write/data_out port. Sub-word stores are implemented as read-modify-write of the containing aligned word. Loads return a lane-extracted, sign- or zero-extended result. Misaligned and out-of-range accesses are faulted without touching memory.

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: data-side initiator between the pipeline and the memory
// data port. Handles one byte/halfword/word access at a time. Sub-word stores
// are done as read-modify-write of the aligned word. Misaligned or
// out-of-range accesses are faulted without touching memory.
module load_store_unit #(
  parameter logic [31:0] DATA_TOP = 32'h0000_2FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] data_addr,
  output logic [31:0] data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_fault;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_in;

  logic        w_accept;
  logic        w_fault;
  logic [31:0] w_word_addr;

  // Pull the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  off,
                                            input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the target lane of a word with the low bytes of the store data.
  function automatic logic [31:0] f_merge(input logic [31:0] word,
                                          input logic [31:0] wd,
                                          input logic [1:0]  size,
                                          input logic [1:0]  off);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  assign w_accept    = req_valid && req_ready;
  assign w_word_addr = {req_addr[31:2], 2'b00};
  assign w_fault     = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || (w_word_addr > DATA_TOP);

  // State register; reset forces IDLE so memory enables drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault)                              w_next = S_RESP;
          else if (req_write && req_size == 2'b10)  w_next = S_WRITE;
          else                                      w_next = S_READ;
        end
      end
      S_READ:  w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and memory enables decoded from the current state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (r_state)
      S_IDLE:  req_ready  = !rst;
      S_READ:  mem_read   = 1'b1;
      S_WRITE: mem_write  = 1'b1;
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture, read-data capture/merge and memory address/data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_fault <= 1'b0;
      r_data_addr  <= 32'h0;
      r_data_in    <= 32'h0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_write      <= req_write;
      r_size       <= req_size;
      r_unsigned   <= req_unsigned;
      r_off        <= req_addr[1:0];
      r_wdata      <= req_wdata;
      r_resp_rdata <= 32'h0;
      r_resp_fault <= w_fault;
      if (!w_fault) begin
        r_data_addr <= w_word_addr;
        if (req_write && req_size == 2'b10) r_data_in <= req_wdata;
      end
    end else if (r_state == S_READ) begin
      if (r_write) r_data_in    <= f_merge(data_out, r_wdata, r_size, r_off);
      else         r_resp_rdata <= f_extract(data_out, r_size, r_off, r_unsigned);
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;
  assign data_addr  = r_data_addr;
  assign data_in    = r_data_in;

endmodule
